// File: rtl/frame_dump_ctrl_pkg.sv
// Shared definitions for the frame-keyed capture window scheduler.
// Contents:
//   DEF_CNTW / DEF_LENW / DEF_WINW : default counter widths
//   ST_*                           : state encodings (3 bits)
//   state_t                        : FSM state type built on the ST_* codes
package frame_dump_ctrl_pkg;

    localparam int DEF_CNTW = 32;
    localparam int DEF_LENW = 16;
    localparam int DEF_WINW = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ARMED  = ST_ARMED,
        S_ACTIVE = ST_ACTIVE,
        S_GAP    = ST_GAP,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/frame_dump_fcnt.sv
// Vertical-sync falling-edge detector and completed-frame counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   vs         : vertical sync, a frame ends on its falling edge
//   frame_stb  : registered 1-cycle pulse, the cycle after the edge is sampled
//   frame_cnt  : completed frames; bumps on the frame_stb cycle, wraps
module frame_dump_fcnt
    import frame_dump_ctrl_pkg::*;
#(
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vs,
    output logic            frame_stb,
    output logic [CNTW-1:0] frame_cnt
);

    logic            vs_l_q, vs_l_d;
    logic            frame_stb_q, frame_stb_d;
    logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        vs_l_d      = vs;
        frame_stb_d = vs_l_q & ~vs;
        frame_cnt_d = frame_cnt_q;
        // The count advances off the registered strobe, so consumers see the
        // pre-increment value during the frame_stb cycle.
        if (frame_stb_q) begin
            frame_cnt_d = frame_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_l_q      <= 1'b0;
            frame_stb_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_l_q      <= vs_l_d;
            frame_stb_q <= frame_stb_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_stb = frame_stb_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Capture-window scheduler keyed on video frame number. After arm it waits
// for frame cfg_start, opens a window of cfg_len frames, and optionally
// repeats it after cfg_gap frames (cfg_gap == 0 means one-shot).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   vs                       : vertical sync
//   arm, abort               : 1-cycle requests; abort wins over arm
//   cfg_start/len/gap        : latched only when arming from IDLE or DONE
//   frame_cnt, frame_stb     : frame counter and per-frame strobe
//   dump_on                  : high while a window is open
//   dump_start, dump_stop    : 1-cycle pulses on the dump_on edges
//   armed, done              : state flags for ARMED and DONE
//   win_cnt                  : windows closed since last arm, saturating
module frame_dump_ctrl
    import frame_dump_ctrl_pkg::*;
#(
    parameter int CNTW = DEF_CNTW,
    parameter int LENW = DEF_LENW,
    parameter int WINW = DEF_WINW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vs,
    input  logic            arm,
    input  logic            abort,
    input  logic [CNTW-1:0] cfg_start,
    input  logic [LENW-1:0] cfg_len,
    input  logic [LENW-1:0] cfg_gap,
    output logic [CNTW-1:0] frame_cnt,
    output logic            frame_stb,
    output logic            dump_on,
    output logic            dump_start,
    output logic            dump_stop,
    output logic            armed,
    output logic            done,
    output logic [WINW-1:0] win_cnt
);

    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);
    localparam logic [WINW-1:0] WIN_ONE = WINW'(1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] start_l_q, start_l_d;
    logic [LENW-1:0] len_l_q, len_l_d;
    logic [LENW-1:0] gap_l_q, gap_l_d;
    logic [LENW-1:0] fc_q, fc_d;
    logic [WINW-1:0] win_cnt_q, win_cnt_d;
    logic            dump_on_q, dump_on_d;
    logic            dump_start_q, dump_start_d;
    logic            dump_stop_q, dump_stop_d;

    frame_dump_fcnt #(.CNTW(CNTW)) u_fcnt (
        .clk       (clk),
        .rst       (rst),
        .vs        (vs),
        .frame_stb (frame_stb),
        .frame_cnt (frame_cnt)
    );

    always_comb begin
        state_d      = state_q;
        start_l_d    = start_l_q;
        len_l_d      = len_l_q;
        gap_l_d      = gap_l_q;
        fc_d         = fc_q;
        win_cnt_d    = win_cnt_q;
        dump_on_d    = dump_on_q;
        dump_start_d = 1'b0;
        dump_stop_d  = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            fc_d    = '0;
            if (state_q == S_ACTIVE) begin
                dump_stop_d = 1'b1;
                dump_on_d   = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        start_l_d = cfg_start;
                        len_l_d   = cfg_len;
                        gap_l_d   = cfg_gap;
                        win_cnt_d = '0;
                        fc_d      = '0;
                        // A zero-length window has nothing to capture.
                        state_d   = (cfg_len == '0) ? S_DONE : S_ARMED;
                    end
                end
                S_ARMED: begin
                    // Exact match only: a start already passed waits for wrap.
                    if (frame_stb && (frame_cnt == start_l_q)) begin
                        state_d      = S_ACTIVE;
                        fc_d         = '0;
                        dump_start_d = 1'b1;
                        dump_on_d    = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (frame_stb) begin
                        if (fc_q == len_l_q - LEN_ONE) begin
                            dump_stop_d = 1'b1;
                            dump_on_d   = 1'b0;
                            fc_d        = '0;
                            if (win_cnt_q != '1) begin
                                win_cnt_d = win_cnt_q + WIN_ONE;
                            end
                            state_d = (gap_l_q == '0) ? S_DONE : S_GAP;
                        end else begin
                            fc_d = fc_q + LEN_ONE;
                        end
                    end
                end
                S_GAP: begin
                    if (frame_stb) begin
                        if (fc_q == gap_l_q - LEN_ONE) begin
                            fc_d         = '0;
                            state_d      = S_ACTIVE;
                            dump_start_d = 1'b1;
                            dump_on_d    = 1'b1;
                        end else begin
                            fc_d = fc_q + LEN_ONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_l_q    <= '0;
            len_l_q      <= '0;
            gap_l_q      <= '0;
            fc_q         <= '0;
            win_cnt_q    <= '0;
            dump_on_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_stop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_l_q    <= start_l_d;
            len_l_q      <= len_l_d;
            gap_l_q      <= gap_l_d;
            fc_q         <= fc_d;
            win_cnt_q    <= win_cnt_d;
            dump_on_q    <= dump_on_d;
            dump_start_q <= dump_start_d;
            dump_stop_q  <= dump_stop_d;
        end
    end

    assign dump_on    = dump_on_q;
    assign dump_start = dump_start_q;
    assign dump_stop  = dump_stop_q;
    assign armed      = (state_q == S_ARMED);
    assign done       = (state_q == S_DONE);
    assign win_cnt    = win_cnt_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
module tb_frame_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        vs = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_start = '0;
    logic [15:0] cfg_len = '0;
    logic [15:0] cfg_gap = '0;

    logic [31:0] frame_cnt;
    logic        frame_stb, dump_on, dump_start, dump_stop, armed, done;
    logic [7:0]  win_cnt;

    logic        arm4 = 1'b0;
    logic        abort4 = 1'b0;
    logic [3:0]  cfg_start4 = '0;
    logic [3:0]  frame_cnt4;
    logic        frame_stb4, dump_on4, dump_start4, dump_stop4, armed4, done4;
    logic [7:0]  win_cnt4;

    frame_dump_ctrl dut (
        .clk(clk), .rst(rst), .vs(vs), .arm(arm), .abort(abort),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
        .frame_cnt(frame_cnt), .frame_stb(frame_stb), .dump_on(dump_on),
        .dump_start(dump_start), .dump_stop(dump_stop), .armed(armed),
        .done(done), .win_cnt(win_cnt)
    );

    frame_dump_ctrl #(.CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .vs(vs), .arm(arm4), .abort(abort4),
        .cfg_start(cfg_start4), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
        .frame_cnt(frame_cnt4), .frame_stb(frame_stb4), .dump_on(dump_on4),
        .dump_start(dump_start4), .dump_stop(dump_stop4), .armed(armed4),
        .done(done4), .win_cnt(win_cnt4)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Event monitor: counts pulses, logs frame_cnt at each window open and
    // flags dump_on edges without their matching pulse or stretched pulses.
    int          stb_n = 0, start_n = 0, stop_n = 0, edge_err = 0, start4_n = 0;
    logic [31:0] start_fc[$];
    logic [3:0]  start4_fc[$];
    logic        on_prev = 1'b0, st_prev = 1'b0, sp_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            on_prev = 1'b0; st_prev = 1'b0; sp_prev = 1'b0;
        end else begin
            if (frame_stb) stb_n++;
            if (dump_start) begin start_n++; start_fc.push_back(frame_cnt); end
            if (dump_stop) stop_n++;
            if ((dump_on !== on_prev) && !(dump_on ? dump_start : dump_stop)) edge_err++;
            if ((dump_start && st_prev) || (dump_stop && sp_prev)) edge_err++;
            on_prev = dump_on; st_prev = dump_start; sp_prev = dump_stop;
            if (dump_start4) begin start4_n++; start4_fc.push_back(frame_cnt4); end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1; tick(3);
            vs = 1'b0; tick(3);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b0; arm = 1'b0; abort = 1'b0; arm4 = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic pulse_arm(input logic [31:0] s, input logic [15:0] l, input logic [15:0] g);
        cfg_start = s; cfg_len = l; cfg_gap = g;
        arm = 1'b1; tick(1); arm = 1'b0;
    endtask

    int b_stb, b_start, b_stop, b4;

    initial begin
        // Reset state, then free-running frames with no arm.
        do_reset();
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_flags", {frame_stb, dump_on, dump_start, dump_stop, armed, done}, 0);
        chk("rst_win_cnt", win_cnt, 0);
        b_stb = stb_n;
        frames(5);
        chk("idle_stb_count", stb_n - b_stb, 5);
        chk("idle_frame_cnt", frame_cnt, 5);
        chk("idle_no_start", start_n, 0);
        chk("idle_flags", {dump_on, armed, done}, 0);

        // One-shot: start=3 len=2 gap=0.
        do_reset();
        pulse_arm(3, 2, 0);
        chk("oneshot_armed", armed, 1);
        b_start = start_n; b_stop = stop_n;
        frames(4);
        chk("oneshot_on", dump_on, 1);
        chk("oneshot_start_fc", start_fc[b_start], 4);
        frames(2);
        chk("oneshot_starts", start_n - b_start, 1);
        chk("oneshot_stops", stop_n - b_stop, 1);
        chk("oneshot_done", {done, armed, dump_on}, 3'b100);
        chk("oneshot_win_cnt", win_cnt, 1);

        // Repeating: start=2 len=1 gap=2 -> opens at frames 2, 5, 8, 11.
        do_reset();
        pulse_arm(2, 1, 2);
        b_start = start_n; b_stop = stop_n;
        frames(12);
        chk("rep_starts", start_n - b_start, 4);
        chk("rep_start_fc0", start_fc[b_start], 3);
        chk("rep_start_fc1", start_fc[b_start + 1], 6);
        chk("rep_start_fc2", start_fc[b_start + 2], 9);
        chk("rep_start_fc3", start_fc[b_start + 3], 12);
        chk("rep_stops", stop_n - b_stop, 3);
        chk("rep_win_cnt", win_cnt, 3);
        chk("rep_not_done", {done, dump_on}, 2'b01);

        // Reset mid-window drops dump_on with no dump_stop.
        rst = 1'b1; tick(1);
        chk("rst_mid_window", {dump_on, dump_stop}, 0);

        // Abort in the 2nd frame of a len=4 window (2nd window, win_cnt=1).
        do_reset();
        pulse_arm(0, 4, 1);
        b_start = start_n;
        frames(7);
        chk("abort_pre_on", dump_on, 1);
        chk("abort_pre_win", win_cnt, 1);
        chk("abort_pre_starts", start_n - b_start, 2);
        pulse_arm(0, 0, 0);
        chk("arm_ignored_active", {done, dump_on}, 2'b01);
        b_stop = stop_n;
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("abort_stop_edge", {dump_stop, dump_on}, 2'b10);
        chk("abort_idle", {armed, done}, 0);
        chk("abort_win_held", win_cnt, 1);
        frames(3);
        chk("abort_stays_idle", start_n - b_start, 2);
        chk("abort_one_stop", stop_n - b_stop, 1);

        // arm and abort together from IDLE, then a zero-length arm.
        cfg_start = 0; cfg_len = 3; cfg_gap = 0;
        arm = 1'b1; abort = 1'b1; tick(1); arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", {armed, done}, 0);
        b_start = start_n;
        frames(2);
        chk("arm_abort_no_start", start_n - b_start, 0);
        pulse_arm(0, 0, 0);
        chk("len0_done", {done, armed}, 2'b10);
        chk("len0_win_clr", win_cnt, 0);
        frames(2);
        chk("len0_no_start", start_n - b_start, 0);
        chk("len0_stays_done", {done, dump_on}, 2'b10);

        // 4-bit counter: arm at frame 10 with start=2, opens after the wrap.
        do_reset();
        frames(10);
        chk("wrap_fc_at_arm", frame_cnt4, 10);
        cfg_start4 = 4'd2; cfg_len = 1; cfg_gap = 0;
        arm4 = 1'b1; tick(1); arm4 = 1'b0;
        chk("wrap_armed", armed4, 1);
        b4 = start4_n;
        frames(8);
        chk("wrap_no_early", start4_n - b4, 0);
        chk("wrap_fc_wrapped", frame_cnt4, 2);
        chk("wide_fc_no_wrap", frame_cnt, 18);
        frames(1);
        chk("wrap_opened", start4_n - b4, 1);
        chk("wrap_start_fc", start4_fc[b4], 3);
        chk("wrap_on", dump_on4, 1);
        frames(1);
        chk("wrap_done", {done4, dump_on4}, 2'b10);
        chk("wrap_win_cnt", win_cnt4, 1);

        chk("edge_pulse_pairing", edge_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_dump_ctrl.md
Name: frame_dump_ctrl

Overview:
Synthesizable scheduler for waveform and trace capture windows, keyed on video frame number.
- Derives a frame counter from the vertical sync signal.
- Arms on request, then opens a capture window of a programmed number of frames at a programmed start frame.
- Optionally repeats the window after a gap.
- Sits between the game top's video timing and the simulation dump logic or an on-chip trace logger, which consume its pulses and level.

Parameters:
CNTW, 32, frame counter width
LENW, 16, width of window length and gap counters
WINW, 8, width of completed-window counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vs  in  1  vertical sync, active high; a frame ends on its falling edge
arm  in  1  1-cycle request to latch config and arm
abort  in  1  1-cycle request to cancel any activity
cfg_start  in  CNTW  frame number at which the first window opens
cfg_len  in  LENW  window length in frames
cfg_gap  in  LENW  frames between a window close and the next open; 0 means one-shot
frame_cnt  out  CNTW  completed-frame count
frame_stb  out  1  1-cycle pulse at each detected vs falling edge
dump_on  out  1  high while a window is open
dump_start  out  1  1-cycle pulse when a window opens
dump_stop  out  1  1-cycle pulse when a window closes
armed  out  1  high in ARMED
done  out  1  high in DONE
win_cnt  out  WINW  completed windows since last arm; saturates at all-ones

Behaviour:
- Reset value 0 for all outputs, state IDLE, and internal vs_l.
- Edge detect: vs_l <= vs each cycle. frame_stb = vs_l & ~vs, registered, so it asserts the cycle after the falling edge is sampled.
- frame_cnt increments on the frame_stb cycle; the new value is visible the next cycle. It wraps modulo 2^CNTW and runs in every state.
- States: IDLE, ARMED, ACTIVE, GAP, DONE.
- IDLE or DONE, arm=1:
  - Latch cfg_start, cfg_len and cfg_gap; clear win_cnt.
  - Next state is ARMED, or DONE if cfg_len==0.
  - cfg_* are ignored at all other times.
- ARMED, frame_stb && frame_cnt==start_l (pre-increment value):
  - Go to ACTIVE; dump_start=1 and dump_on=1 from the next cycle.
  - If start_l has already passed, wait for counter wrap.
- ACTIVE:
  - Frame counter fc increments on each frame_stb.
  - On the frame_stb where fc==len_l-1: dump_stop pulse, dump_on falls, win_cnt++, fc cleared.
  - Next state is DONE if gap_l==0, else GAP.
  - Window length is therefore exactly len_l frames.
- GAP:
  - fc increments on each frame_stb.
  - On the frame_stb where fc==gap_l-1: fc cleared, ACTIVE, dump_start pulse.
- dump_start and dump_stop are registered, 1-cycle pulses, coincident with the dump_on edge.
- abort: from any state go to IDLE next cycle; fc cleared; win_cnt held.
  - If in ACTIVE, dump_stop pulses and dump_on falls on the same edge.
  - abort and arm in the same cycle: abort wins; arm is dropped.
- arm while ARMED, ACTIVE or GAP is ignored.
- rst mid-window: dump_on drops with no dump_stop pulse.
- vs stuck high or low: no frame_stb; the state machine waits indefinitely.

Decomposition:
- Shared package or include:
  - State encoding localparams ST_IDLE=0, ST_ARMED=1, ST_ACTIVE=2, ST_GAP=3, ST_DONE=4, 3 bits.
  - Default CNTW and LENW values.
- One natural sub-module, frame_dump_fcnt: vs edge detector plus frame counter, producing frame_stb and frame_cnt.
- The state machine, latches and window/gap counter stay in frame_dump_ctrl.

Test Plan:
- Reset then 5 vs pulses, no arm -> frame_stb ×5, frame_cnt=5, dump_on never high, outputs otherwise 0.
- arm with start=3, len=2, gap=0 at frame_cnt=0 -> dump_start in the cycle after the frame_stb with frame_cnt==3; dump_on high for 2 frames; dump_stop; done=1; win_cnt=1.
- arm with start=2, len=1, gap=2 -> windows open at frames 2, 5, 8, …; win_cnt counts 1, 2, 3; done stays 0.
- abort during the 2nd frame of a len=4 window -> dump_stop and dump_on fall on the same edge; state IDLE; win_cnt unchanged.
- arm and abort in the same cycle from IDLE -> stays IDLE, armed=0. arm with len=0 -> done=1 next cycle, no dump_start.
- CNTW=4, arm at frame_cnt=10 with start=2 -> counter wraps 15→0; window opens at frame 2 after the wrap.
